// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at tail, captures RS/LSB results,
// commits the head in program order and raises a one-cycle flush on redirect.
module reorder_buffer #(
   parameter int RoB_WIDTH = 4,
   parameter int RoB_SIZE  = 1 << RoB_WIDTH,
   parameter int NON_DEP   = 1 << RoB_WIDTH
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 alloc_en,
   input  logic [1:0]           alloc_type,
   input  logic [4:0]           alloc_rd,
   input  logic                 alloc_ready,
   input  logic [31:0]          alloc_value,
   input  logic                 alloc_pred_taken,
   input  logic [31:0]          alloc_alt_pc,
   output logic [RoB_WIDTH-1:0] alloc_index,
   output logic                 isFull,
   output logic                 isEmpty,
   input  logic [RoB_WIDTH-1:0] query_j_index,
   input  logic [RoB_WIDTH-1:0] query_k_index,
   output logic                 query_j_ready,
   output logic                 query_k_ready,
   output logic [31:0]          query_j_data,
   output logic [31:0]          query_k_data,
   input  logic                 RS_update_en,
   input  logic [RoB_WIDTH-1:0] RS_update_index,
   input  logic [31:0]          RS_update_data,
   input  logic                 LSB_update_en,
   input  logic [RoB_WIDTH-1:0] LSB_update_index,
   input  logic [31:0]          LSB_update_data,
   output logic                 commit_reg_en,
   output logic [4:0]           commit_rd,
   output logic [31:0]          commit_data,
   output logic [RoB_WIDTH-1:0] commit_index,
   output logic                 commit_store_en,
   output logic                 flush_signal,
   output logic [31:0]          flush_pc
);
   localparam logic [1:0] T_REG = 2'd0, T_BRANCH = 2'd1, T_STORE = 2'd2, T_JALR = 2'd3;
   // The no-dependency tag is numerically the entry count, i.e. the full level.
   localparam logic [RoB_WIDTH:0] CNT_FULL = (RoB_WIDTH+1)'(NON_DEP);

   logic                 busy_q  [RoB_SIZE];
   logic                 ready_q [RoB_SIZE];
   logic [1:0]           type_q  [RoB_SIZE];
   logic [4:0]           rd_q    [RoB_SIZE];
   logic [31:0]          value_q [RoB_SIZE];
   logic                 pred_q  [RoB_SIZE];
   logic [31:0]          alt_q   [RoB_SIZE];
   logic [RoB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
   logic [RoB_WIDTH:0]   count_q, count_d;
   logic                 reg_en_q, store_en_q, flush_q;
   logic [4:0]           crd_q;
   logic [31:0]          cdata_q, fpc_q;
   logic [RoB_WIDTH-1:0] cidx_q;

   logic do_alloc, do_commit, do_flush, mispred, rs_wb, lsb_wb;
   logic [1:0] head_type;

   assign alloc_index     = tail_q;
   assign isFull          = (count_q == CNT_FULL);
   assign isEmpty         = (count_q == '0);
   assign commit_reg_en   = reg_en_q;
   assign commit_rd       = crd_q;
   assign commit_data     = cdata_q;
   assign commit_index    = cidx_q;
   assign commit_store_en = store_en_q;
   assign flush_signal    = flush_q;
   assign flush_pc        = fpc_q;

   always_comb begin
      head_type = type_q[head_q];
      do_alloc  = alloc_en && !isFull && !flush_q;
      do_commit = busy_q[head_q] && ready_q[head_q];
      mispred   = (head_type == T_BRANCH) && (value_q[head_q][0] != pred_q[head_q]);
      do_flush  = do_commit && (mispred || head_type == T_JALR);
      rs_wb     = RS_update_en && !flush_q && busy_q[RS_update_index];
      lsb_wb    = LSB_update_en && !flush_q && busy_q[LSB_update_index];
      head_d    = head_q + RoB_WIDTH'(do_commit);
      tail_d    = tail_q + RoB_WIDTH'(do_alloc);
      count_d   = count_q + (RoB_WIDTH+1)'(do_alloc) - (RoB_WIDTH+1)'(do_commit);
      if (do_flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // Operand lookup with same-cycle writeback bypass; LSB has the final say.
   always_comb begin
      query_j_ready = busy_q[query_j_index] && ready_q[query_j_index];
      query_j_data  = value_q[query_j_index];
      query_k_ready = busy_q[query_k_index] && ready_q[query_k_index];
      query_k_data  = value_q[query_k_index];
      if (RS_update_en && RS_update_index == query_j_index) begin
         query_j_ready = 1'b1;
         query_j_data  = RS_update_data;
      end
      if (LSB_update_en && LSB_update_index == query_j_index) begin
         query_j_ready = 1'b1;
         query_j_data  = LSB_update_data;
      end
      if (RS_update_en && RS_update_index == query_k_index) begin
         query_k_ready = 1'b1;
         query_k_data  = RS_update_data;
      end
      if (LSB_update_en && LSB_update_index == query_k_index) begin
         query_k_ready = 1'b1;
         query_k_data  = LSB_update_data;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < RoB_SIZE; i++) begin
            busy_q[i]  <= 1'b0;
            ready_q[i] <= 1'b0;
            type_q[i]  <= T_REG;
            rd_q[i]    <= '0;
            value_q[i] <= '0;
            pred_q[i]  <= 1'b0;
            alt_q[i]   <= '0;
         end
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         reg_en_q   <= 1'b0;
         store_en_q <= 1'b0;
         flush_q    <= 1'b0;
         crd_q      <= '0;
         cdata_q    <= '0;
         cidx_q     <= '0;
         fpc_q      <= '0;
      end else if (rdy_in) begin
         reg_en_q   <= 1'b0;
         store_en_q <= 1'b0;
         flush_q    <= 1'b0;
         if (do_alloc) begin
            busy_q[tail_q]  <= 1'b1;
            ready_q[tail_q] <= alloc_ready;
            type_q[tail_q]  <= alloc_type;
            rd_q[tail_q]    <= alloc_rd;
            pred_q[tail_q]  <= alloc_pred_taken;
            // JALR keeps its link value (pc+4) in the alt_pc slot; value gets the target.
            if (alloc_type == T_JALR) begin
               alt_q[tail_q]   <= alloc_value;
               value_q[tail_q] <= '0;
            end else begin
               alt_q[tail_q]   <= alloc_alt_pc;
               value_q[tail_q] <= alloc_value;
            end
         end
         if (rs_wb) begin
            value_q[RS_update_index] <= RS_update_data;
            ready_q[RS_update_index] <= 1'b1;
         end
         if (lsb_wb) begin
            value_q[LSB_update_index] <= LSB_update_data;
            ready_q[LSB_update_index] <= 1'b1;
         end
         if (do_commit) begin
            busy_q[head_q] <= 1'b0;
            cidx_q         <= head_q;
            case (head_type)
               T_REG: begin
                  reg_en_q <= 1'b1;
                  crd_q    <= rd_q[head_q];
                  cdata_q  <= value_q[head_q];
               end
               T_STORE: store_en_q <= 1'b1;
               T_BRANCH: if (mispred) begin
                  flush_q <= 1'b1;
                  fpc_q   <= alt_q[head_q];
               end
               default: begin
                  reg_en_q <= 1'b1;
                  crd_q    <= rd_q[head_q];
                  cdata_q  <= alt_q[head_q];
                  flush_q  <= 1'b1;
                  fpc_q    <= value_q[head_q] & ~32'd1;
               end
            endcase
         end
         if (do_flush)
            for (int i = 0; i < RoB_SIZE; i++) busy_q[i] <= 1'b0;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: commit order, full/wrap,
// flush on branch/jalr, query bypass, stall and async reset.
module tb_reorder_buffer;
   logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1;
   logic        alloc_en = 1'b0, alloc_ready = 1'b0, alloc_pred_taken = 1'b0;
   logic [1:0]  alloc_type = 2'd0;
   logic [4:0]  alloc_rd = '0;
   logic [31:0] alloc_value = '0, alloc_alt_pc = '0;
   logic [3:0]  alloc_index, query_j_index = '0, query_k_index = '0;
   logic        isFull, isEmpty, query_j_ready, query_k_ready;
   logic [31:0] query_j_data, query_k_data;
   logic        RS_update_en = 1'b0, LSB_update_en = 1'b0;
   logic [3:0]  RS_update_index = '0, LSB_update_index = '0;
   logic [31:0] RS_update_data = '0, LSB_update_data = '0;
   logic        commit_reg_en, commit_store_en, flush_signal;
   logic [4:0]  commit_rd;
   logic [31:0] commit_data, flush_pc;
   logic [3:0]  commit_index;
   int n_chk = 0, n_fail = 0;

   reorder_buffer dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .alloc_en(alloc_en), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
      .alloc_ready(alloc_ready), .alloc_value(alloc_value),
      .alloc_pred_taken(alloc_pred_taken), .alloc_alt_pc(alloc_alt_pc),
      .alloc_index(alloc_index), .isFull(isFull), .isEmpty(isEmpty),
      .query_j_index(query_j_index), .query_k_index(query_k_index),
      .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
      .query_j_data(query_j_data), .query_k_data(query_k_data),
      .RS_update_en(RS_update_en), .RS_update_index(RS_update_index),
      .RS_update_data(RS_update_data),
      .LSB_update_en(LSB_update_en), .LSB_update_index(LSB_update_index),
      .LSB_update_data(LSB_update_data),
      .commit_reg_en(commit_reg_en), .commit_rd(commit_rd),
      .commit_data(commit_data), .commit_index(commit_index),
      .commit_store_en(commit_store_en), .flush_signal(flush_signal),
      .flush_pc(flush_pc)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic alloc(input logic [1:0] t, input logic [4:0] rd, input logic rdy,
                        input logic [31:0] v, input logic pt, input logic [31:0] alt);
      alloc_en = 1'b1; alloc_type = t; alloc_rd = rd; alloc_ready = rdy;
      alloc_value = v; alloc_pred_taken = pt; alloc_alt_pc = alt;
      tick();
      alloc_en = 1'b0;
   endtask

   task automatic rs_wb(input logic [3:0] idx, input logic [31:0] d);
      RS_update_en = 1'b1; RS_update_index = idx; RS_update_data = d;
      tick();
      RS_update_en = 1'b0;
   endtask

   task automatic lsb_wb(input logic [3:0] idx, input logic [31:0] d);
      LSB_update_en = 1'b1; LSB_update_index = idx; LSB_update_data = d;
      tick();
      LSB_update_en = 1'b0;
   endtask

   task automatic async_reset();
      #2 rst_in = 1'b0;
      #1;
      chk("rst_isEmpty", 32'(isEmpty), 32'd1);
      chk("rst_alloc_index", 32'(alloc_index), 32'd0);
      chk("rst_isFull", 32'(isFull), 32'd0);
      chk("rst_reg_en", 32'(commit_reg_en), 32'd0);
      chk("rst_flush", 32'(flush_signal), 32'd0);
      tick();
      rst_in = 1'b1;
   endtask

   initial begin
      #1;
      chk("reset_isEmpty", 32'(isEmpty), 32'd1);
      chk("reset_commit_rd", 32'(commit_rd), 32'd0);
      chk("reset_commit_data", commit_data, 32'd0);
      chk("reset_flush_pc", flush_pc, 32'd0);
      chk("reset_store_en", 32'(commit_store_en), 32'd0);
      tick(); tick();
      rst_in = 1'b1;

      // single REG commit
      chk("t1_alloc_index0", 32'(alloc_index), 32'd0);
      alloc(2'd0, 5'd5, 1'b0, 32'd0, 1'b0, 32'd0);
      chk("t1_alloc_index1", 32'(alloc_index), 32'd1);
      chk("t1_not_empty", 32'(isEmpty), 32'd0);
      rs_wb(4'd0, 32'h1234);
      chk("t1_no_early_commit", 32'(commit_reg_en), 32'd0);
      tick();
      chk("t1_reg_en", 32'(commit_reg_en), 32'd1);
      chk("t1_rd", 32'(commit_rd), 32'd5);
      chk("t1_data", commit_data, 32'h1234);
      chk("t1_index", 32'(commit_index), 32'd0);
      chk("t1_empty", 32'(isEmpty), 32'd1);
      tick();
      chk("t1_pulse_end", 32'(commit_reg_en), 32'd0);

      // fill to 16, overflow ignored, commit then wrap
      async_reset();
      alloc_en = 1'b1; alloc_type = 2'd0; alloc_ready = 1'b0; alloc_rd = 5'd3;
      for (int i = 0; i < 16; i++) tick();
      chk("full_isFull", 32'(isFull), 32'd1);
      chk("full_tail", 32'(alloc_index), 32'd0);
      tick();
      chk("full_17th_tail", 32'(alloc_index), 32'd0);
      chk("full_17th_isFull", 32'(isFull), 32'd1);
      RS_update_en = 1'b1; RS_update_index = 4'd0; RS_update_data = 32'hA0;
      tick();
      RS_update_en = 1'b0;
      tick();
      chk("full_commit_idx", 32'(commit_index), 32'd0);
      chk("full_commit_en", 32'(commit_reg_en), 32'd1);
      chk("full_commit_blocks_alloc", 32'(alloc_index), 32'd0);
      chk("full_not_full", 32'(isFull), 32'd0);
      tick();
      alloc_en = 1'b0;
      chk("wrap_tail", 32'(alloc_index), 32'd1);
      chk("wrap_full", 32'(isFull), 32'd1);
      async_reset();

      // out-of-order writeback, in-order commit
      alloc(2'd0, 5'd1, 1'b0, 32'd0, 1'b0, 32'd0);
      alloc(2'd0, 5'd2, 1'b0, 32'd0, 1'b0, 32'd0);
      alloc(2'd0, 5'd3, 1'b0, 32'd0, 1'b0, 32'd0);
      rs_wb(4'd2, 32'h22);
      lsb_wb(4'd1, 32'h11);
      rs_wb(4'd0, 32'h10);
      chk("ooo_wait", 32'(commit_reg_en), 32'd0);
      tick();
      chk("ooo_c0_idx", 32'(commit_index), 32'd0);
      chk("ooo_c0_data", commit_data, 32'h10);
      tick();
      chk("ooo_c1_idx", 32'(commit_index), 32'd1);
      chk("ooo_c1_rd", 32'(commit_rd), 32'd2);
      chk("ooo_c1_data", commit_data, 32'h11);
      tick();
      chk("ooo_c2_idx", 32'(commit_index), 32'd2);
      chk("ooo_c2_en", 32'(commit_reg_en), 32'd1);
      chk("ooo_c2_data", commit_data, 32'h22);
      tick();
      chk("ooo_done", 32'(commit_reg_en), 32'd0);
      chk("ooo_empty", 32'(isEmpty), 32'd1);

      // mispredicted branch at idx3 with a younger ready entry
      alloc(2'd1, 5'd0, 1'b0, 32'd0, 1'b0, 32'h100);
      alloc(2'd0, 5'd7, 1'b1, 32'h77, 1'b0, 32'd0);
      rs_wb(4'd3, 32'd1);
      tick();
      chk("br_flush", 32'(flush_signal), 32'd1);
      chk("br_flush_pc", flush_pc, 32'h100);
      chk("br_no_reg", 32'(commit_reg_en), 32'd0);
      chk("br_empty", 32'(isEmpty), 32'd1);
      chk("br_tail0", 32'(alloc_index), 32'd0);
      alloc(2'd0, 5'd8, 1'b1, 32'h88, 1'b0, 32'd0);
      chk("br_alloc_ignored", 32'(alloc_index), 32'd0);
      chk("br_flush_end", 32'(flush_signal), 32'd0);
      tick();
      chk("br_younger_dropped", 32'(commit_reg_en), 32'd0);

      // jalr: link value pc+4, target from writeback
      alloc(2'd3, 5'd1, 1'b0, 32'h50, 1'b0, 32'd0);
      lsb_wb(4'd0, 32'h203);
      tick();
      chk("jalr_flush", 32'(flush_signal), 32'd1);
      chk("jalr_flush_pc", flush_pc, 32'h202);
      chk("jalr_reg_en", 32'(commit_reg_en), 32'd1);
      chk("jalr_rd", 32'(commit_rd), 32'd1);
      chk("jalr_data", commit_data, 32'h50);
      tick();
      chk("jalr_pulse_end", 32'(flush_signal), 32'd0);

      // query bypass and RS/LSB collision
      for (int i = 0; i < 4; i++) alloc(2'd0, 5'(i + 1), 1'b0, 32'd0, 1'b0, 32'd0);
      query_j_index = 4'd3; query_k_index = 4'd2;
      #1;
      chk("q_not_ready", 32'(query_j_ready), 32'd0);
      LSB_update_en = 1'b1; LSB_update_index = 4'd3; LSB_update_data = 32'hAB;
      #1;
      chk("q_bypass_ready", 32'(query_j_ready), 32'd1);
      chk("q_bypass_data", query_j_data, 32'hAB);
      chk("q_k_not_ready", 32'(query_k_ready), 32'd0);
      tick();
      RS_update_en = 1'b1; RS_update_index = 4'd2; RS_update_data = 32'h55;
      LSB_update_en = 1'b1; LSB_update_index = 4'd2; LSB_update_data = 32'h66;
      #1;
      chk("q_collide_bypass", query_k_data, 32'h66);
      tick();
      RS_update_en = 1'b0; LSB_update_en = 1'b0;
      #1;
      chk("q_collide_stored_rdy", 32'(query_k_ready), 32'd1);
      chk("q_collide_stored", query_k_data, 32'h66);
      chk("q_j_stored", query_j_data, 32'hAB);
      async_reset();

      // pre-ready alloc at head, stall holds the pulse, store commit
      alloc(2'd0, 5'd9, 1'b1, 32'h99, 1'b0, 32'd0);
      tick();
      chk("rdy_commit_en", 32'(commit_reg_en), 32'd1);
      chk("rdy_commit_data", commit_data, 32'h99);
      rdy_in = 1'b0;
      tick(); tick();
      chk("stall_hold_en", 32'(commit_reg_en), 32'd1);
      rdy_in = 1'b1;
      tick();
      chk("stall_release", 32'(commit_reg_en), 32'd0);
      alloc(2'd2, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      rs_wb(4'd1, 32'h4);
      tick();
      chk("store_en", 32'(commit_store_en), 32'd1);
      chk("store_no_reg", 32'(commit_reg_en), 32'd0);
      chk("store_index", 32'(commit_index), 32'd1);
      tick();
      chk("store_pulse_end", 32'(commit_store_en), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
